// File: rtl/instr_pkg.sv
// Instruction and response formats shared between the CPU link, the
// instruction queue and the NMCU control unit.
package instr_pkg;
  typedef enum logic [3:0] {
    INSTR_NOP   = 4'h0,
    INSTR_LOAD  = 4'h1,
    INSTR_STORE = 4'h2,
    INSTR_MAC   = 4'h3,
    INSTR_HALT  = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    logic [15:0] imm;
  } instruction_t;

  localparam logic [1:0] RESP_STATUS_OK   = 2'b00;
  localparam logic [1:0] RESP_STATUS_HALT = 2'b01;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
  } nmcu_cpu_resp_t;
endpackage

// File: rtl/nmcu_pkg.sv
// NMCU-wide configuration constants.
package nmcu_pkg;
  localparam int IQ_DEPTH = 4;
endpackage

// File: rtl/nmcu_sync_fifo.sv
// Generic synchronous FIFO, type-parameterised. The occupancy counter is the
// only full/empty reference; storage is not reset.
module nmcu_sync_fifo #(
  parameter int  DEPTH     = 4,
  parameter int  CNT_WIDTH = $clog2(DEPTH) + 1,
  parameter type T         = logic [7:0]
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  T                     data_i,
  input  logic                 pop_i,
  output T                     data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] occupancy_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  T                     mem_q [DEPTH];

  // Pointers are exactly log2(DEPTH) bits, so wrap is free.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign full_o      = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign occupancy_o = cnt_q;

  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) pop_i  |-> !empty_o);
  a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) push_i |-> !full_o);
endmodule

// File: rtl/nmcu_instr_queue.sv
// CPU->control-unit instruction queue with one-entry response buffer and HALT
// gating. Optional stats counters are built when NMCU_IQ_STATS_EN is defined.
module nmcu_instr_queue import instr_pkg::*; #(
  parameter int DEPTH     = nmcu_pkg::IQ_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_instr_valid_i,
  input  instruction_t         cpu_instruction_i,
  output logic                 cpu_instr_ready_o,
  output logic                 cu_instr_valid_o,
  output instruction_t         cu_instruction_o,
  input  logic                 cu_instr_ready_i,
  input  logic                 cu_resp_valid_i,
  input  nmcu_cpu_resp_t       cu_response_i,
  output logic                 cu_resp_ready_o,
  output logic                 cpu_resp_valid_o,
  output nmcu_cpu_resp_t       cpu_response_o,
  input  logic                 cpu_resp_ready_i,
  output logic [CNT_WIDTH-1:0] occupancy_o,
  output logic                 halted_o,
  output logic [15:0]          instr_count_o,
  output logic [15:0]          resp_count_o
);
  logic           full, empty, push, pop, cu_resp_hs, cpu_resp_hs;
  logic           halted_q, halted_d, resp_vld_q, resp_vld_d;
  nmcu_cpu_resp_t resp_q, resp_d;

  assign cpu_instr_ready_o = !full && !halted_q;
  assign cu_instr_valid_o  = !empty;
  assign push              = cpu_instr_valid_i && cpu_instr_ready_o;
  assign pop               = cu_instr_valid_o && cu_instr_ready_i;

  nmcu_sync_fifo #(
    .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .T(instruction_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .data_i      (cpu_instruction_i),
    .pop_i       (pop),
    .data_o      (cu_instruction_o),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy_o)
  );

  assign cu_resp_ready_o  = !resp_vld_q;
  assign cpu_resp_valid_o = resp_vld_q;
  assign cpu_response_o   = resp_q;
  assign cu_resp_hs       = cu_resp_valid_i && cu_resp_ready_o;
  assign cpu_resp_hs      = cpu_resp_valid_o && cpu_resp_ready_i;
  assign halted_o         = halted_q;

  // A HALT push takes priority; clear cannot coincide with it in legal use.
  always_comb begin
    halted_d = halted_q;
    if (cpu_resp_hs && resp_q.status == RESP_STATUS_HALT) halted_d = 1'b0;
    if (push && cpu_instruction_i.opcode == INSTR_HALT)   halted_d = 1'b1;
    resp_vld_d = resp_vld_q;
    resp_d     = resp_q;
    if (cu_resp_hs) begin
      resp_vld_d = 1'b1;
      resp_d     = cu_response_i;
    end else if (cpu_resp_hs) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      resp_vld_q <= 1'b0;
    end else begin
      halted_q   <= halted_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  always_ff @(posedge clk) resp_q <= resp_d;

`ifdef NMCU_IQ_STATS_EN
  logic [15:0] icnt_q, icnt_d, rcnt_q, rcnt_d;
  assign icnt_d = push        ? icnt_q + 16'd1 : icnt_q;
  assign rcnt_d = cpu_resp_hs ? rcnt_q + 16'd1 : rcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      rcnt_q <= rcnt_d;
    end
  end
  assign instr_count_o = icnt_q;
  assign resp_count_o  = rcnt_q;
`else
  assign instr_count_o = '0;
  assign resp_count_o  = '0;
`endif

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    cu_resp_valid_i && !cu_resp_ready_o |=> cu_resp_valid_i);
endmodule

// File: tb/tb_nmcu_instr_queue.sv
// Directed bench: queue-based reference model compared every cycle, plus
// literal expectations at each scenario step.
module tb_nmcu_instr_queue;
  import instr_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           cpu_instr_valid_i = 1'b0, cu_instr_ready_i = 1'b0;
  logic           cu_resp_valid_i = 1'b0, cpu_resp_ready_i = 1'b1;
  instruction_t   cpu_instruction_i = '0;
  nmcu_cpu_resp_t cu_response_i = '0;
  logic           cpu_instr_ready_o, cu_instr_valid_o, cu_resp_ready_o;
  logic           cpu_resp_valid_o, halted_o;
  instruction_t   cu_instruction_o;
  nmcu_cpu_resp_t cpu_response_o;
  logic [CW-1:0]  occupancy_o;
  logic [15:0]    instr_count_o, resp_count_o;

  always #5 clk = ~clk;

  nmcu_instr_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_instr_valid_i(cpu_instr_valid_i), .cpu_instruction_i(cpu_instruction_i),
    .cpu_instr_ready_o(cpu_instr_ready_o),
    .cu_instr_valid_o(cu_instr_valid_o), .cu_instruction_o(cu_instruction_o),
    .cu_instr_ready_i(cu_instr_ready_i),
    .cu_resp_valid_i(cu_resp_valid_i), .cu_response_i(cu_response_i),
    .cu_resp_ready_o(cu_resp_ready_o),
    .cpu_resp_valid_o(cpu_resp_valid_o), .cpu_response_o(cpu_response_o),
    .cpu_resp_ready_i(cpu_resp_ready_i),
    .occupancy_o(occupancy_o), .halted_o(halted_o),
    .instr_count_o(instr_count_o), .resp_count_o(resp_count_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic instruction_t mk(input opcode_e op, input logic [15:0] a);
    instruction_t t;
    t = '0;
    t.opcode = op;
    t.addr_a = a;
    t.addr_b = ~a;
    t.imm    = a ^ 16'h5a5a;
    return t;
  endfunction

  // Reference model: a plain queue plus flags, advanced on each clock edge.
  instruction_t   mq[$];
  logic           m_halt = 1'b0, m_rvld = 1'b0;
  nmcu_cpu_resp_t m_resp = '0;
  logic [15:0]    m_icnt = '0, m_rcnt = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit do_push, do_pop, r_load, r_done;
    if (!rst_n) begin
      mq.delete();
      m_halt = 1'b0; m_rvld = 1'b0; m_icnt = '0; m_rcnt = '0;
    end else begin
      do_push = cpu_instr_valid_i && (mq.size() < DEPTH) && !m_halt;
      do_pop  = cu_instr_ready_i && (mq.size() > 0);
      r_done  = m_rvld && cpu_resp_ready_i;
      r_load  = !m_rvld && cu_resp_valid_i;
      if (do_pop) void'(mq.pop_front());
      if (r_done) begin
        m_rvld = 1'b0;
        m_rcnt++;
        if (m_resp.status == RESP_STATUS_HALT) m_halt = 1'b0;
      end
      if (do_push) begin
        mq.push_back(cpu_instruction_i);
        m_icnt++;
        if (cpu_instruction_i.opcode == INSTR_HALT) m_halt = 1'b1;
      end
      if (r_load) begin
        m_rvld = 1'b1;
        m_resp = cu_response_i;
      end
    end
  end

  function automatic logic [15:0] stat(input logic [15:0] v);
`ifdef NMCU_IQ_STATS_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  always @(negedge clk) begin
    chk("cpu_instr_ready", 64'(cpu_instr_ready_o), 64'((mq.size() < DEPTH) && !m_halt));
    chk("cu_instr_valid", 64'(cu_instr_valid_o), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("cu_instruction", 64'(cu_instruction_o), 64'(mq[0]));
    chk("cu_resp_ready", 64'(cu_resp_ready_o), 64'(!m_rvld));
    chk("cpu_resp_valid", 64'(cpu_resp_valid_o), 64'(m_rvld));
    if (m_rvld) chk("cpu_response", 64'(cpu_response_o), 64'(m_resp));
    chk("occupancy", 64'(occupancy_o), 64'(mq.size()));
    chk("halted", 64'(halted_o), 64'(m_halt));
    chk("instr_count", 64'(instr_count_o), 64'(stat(m_icnt)));
    chk("resp_count", 64'(resp_count_o), 64'(stat(m_rcnt)));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push1(input opcode_e op, input logic [15:0] a);
    cpu_instr_valid_i = 1'b1;
    cpu_instruction_i = mk(op, a);
    step();
    cpu_instr_valid_i = 1'b0;
  endtask

  task automatic send_resp(input logic [1:0] st, input logic [31:0] d);
    int w = 0;
    while (!cu_resp_ready_o && w < 20) begin
      step();
      w++;
    end
    chk("resp_buf_free_wait", 64'(cu_resp_ready_o), 64'(1));
    cu_response_i.status = st;
    cu_response_i.data   = d;
    cu_resp_valid_i      = 1'b1;
    step();
    cu_resp_valid_i      = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},     64'(cpu_instr_ready_o), 64'(1));
    chk({tag, "_cu_valid"},  64'(cu_instr_valid_o),  64'(0));
    chk({tag, "_resp_rdy"},  64'(cu_resp_ready_o),   64'(1));
    chk({tag, "_resp_vld"},  64'(cpu_resp_valid_o),  64'(0));
    chk({tag, "_occ"},       64'(occupancy_o),       64'(0));
    chk({tag, "_halted"},    64'(halted_o),          64'(0));
    chk({tag, "_icnt"},      64'(instr_count_o),     64'(0));
    chk({tag, "_rcnt"},      64'(resp_count_o),      64'(0));
  endtask

  initial begin
    step(); step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Single LOAD with control unit stalled.
    push1(INSTR_LOAD, 16'h10);
    chk("load_valid", 64'(cu_instr_valid_o), 64'(1));
    chk("load_occ",   64'(occupancy_o),      64'(1));
    chk("load_addr",  64'(cu_instruction_o.addr_a), 64'(16'h10));
    cu_instr_ready_i = 1'b1; step(); cu_instr_ready_i = 1'b0;
    chk("load_drained", 64'(occupancy_o), 64'(0));

    // Fill to DEPTH; a push during a pop while full must be refused.
    for (int i = 0; i < 4; i++) push1(INSTR_NOP, 16'h20 + 16'(i));
    chk("full_ready", 64'(cpu_instr_ready_o), 64'(0));
    chk("full_occ",   64'(occupancy_o),       64'(4));
    cpu_instr_valid_i = 1'b1; cpu_instruction_i = mk(INSTR_NOP, 16'h99);
    cu_instr_ready_i  = 1'b1;
    step();
    cpu_instr_valid_i = 1'b0; cu_instr_ready_i = 1'b0;
    chk("no_full_bypass_occ", 64'(occupancy_o), 64'(3));
    for (int i = 1; i < 4; i++) begin
      chk("fill_order", 64'(cu_instruction_o.addr_a), 64'(16'h20 + 16'(i)));
      cu_instr_ready_i = 1'b1; step(); cu_instr_ready_i = 1'b0;
    end
    chk("fill_empty", 64'(cu_instr_valid_o), 64'(0));

    // Full-rate streaming across pointer wrap.
    push1(INSTR_STORE, 16'h30);
    for (int i = 1; i < 9; i++) begin
      cpu_instr_valid_i = 1'b1; cpu_instruction_i = mk(INSTR_STORE, 16'h30 + 16'(i));
      cu_instr_ready_i  = 1'b1;
      step();
      chk("stream_occ",  64'(occupancy_o), 64'(1));
      chk("stream_head", 64'(cu_instruction_o.addr_a), 64'(16'h30 + 16'(i)));
    end
    cpu_instr_valid_i = 1'b0;
    step();
    cu_instr_ready_i = 1'b0;
    chk("stream_empty", 64'(occupancy_o), 64'(0));

    // HALT gating.
    push1(INSTR_MAC, 16'h40);
    push1(INSTR_HALT, 16'h41);
    chk("halt_set",   64'(halted_o),          64'(1));
    chk("halt_ready", 64'(cpu_instr_ready_o), 64'(0));
    cpu_instr_valid_i = 1'b1; cpu_instruction_i = mk(INSTR_NOP, 16'h42);
    cu_instr_ready_i  = 1'b1;
    step();
    chk("halt_head", 64'(cu_instruction_o.addr_a), 64'(16'h41));
    chk("halt_occ",  64'(occupancy_o),             64'(1));
    step();
    cpu_instr_valid_i = 1'b0; cu_instr_ready_i = 1'b0;
    chk("halt_drained", 64'(occupancy_o), 64'(0));
    send_resp(RESP_STATUS_OK, 32'd1);
    send_resp(RESP_STATUS_HALT, 32'd2);
    chk("halt_resp_vld",  64'(cpu_resp_valid_o),     64'(1));
    chk("halt_resp_st",   64'(cpu_response_o.status), 64'(2'b01));
    chk("halt_still_set", 64'(halted_o),             64'(1));
    step();
    chk("halt_cleared", 64'(halted_o),          64'(0));
    chk("halt_ready1",  64'(cpu_instr_ready_o), 64'(1));

    // Response back-pressure.
    cpu_resp_ready_i = 1'b0;
    send_resp(RESP_STATUS_OK, 32'd42);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid",   64'(cpu_resp_valid_o),   64'(1));
      chk("bp_data",    64'(cpu_response_o.data), 64'(32'd42));
      chk("bp_cu_rdy",  64'(cu_resp_ready_o),    64'(0));
      step();
    end
    cpu_resp_ready_i = 1'b1;
    step();
    chk("bp_released", 64'(cpu_resp_valid_o), 64'(0));
    chk("bp_cu_rdy1",  64'(cu_resp_ready_o),  64'(1));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) push1(INSTR_LOAD, 16'h50 + 16'(i));
    cpu_resp_ready_i = 1'b0;
    send_resp(RESP_STATUS_OK, 32'd7);
    chk("pre_rst_occ", 64'(occupancy_o),      64'(3));
    chk("pre_rst_rv",  64'(cpu_resp_valid_o), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    cpu_resp_ready_i = 1'b1;
    step();
    push1(INSTR_MAC, 16'h60);
    chk("post_rst_head", 64'(cu_instruction_o.addr_a), 64'(16'h60));
    chk("post_rst_occ",  64'(occupancy_o),             64'(1));
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nmcu_instr_queue.md
# nmcu_instr_queue

Instruction queue and response buffer between the chiplet-side CPU link and the NMCU control unit/decoder. It accepts CPU instructions into a DEPTH-entry FIFO and presents them one at a time to the control unit. It registers the control unit's single-beat responses back toward the CPU. It also enforces HALT semantics: no new instructions are accepted once a HALT has been enqueued, until its response has been delivered.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_WIDTH, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_instr_valid_i  in  1  CPU instruction offered.
- cpu_instruction_i  in  instr_pkg::instruction_t  instruction payload.
- cpu_instr_ready_o  out  1  queue accepts the instruction this cycle.
- cu_instr_valid_o  out  1  head instruction available to the control unit.
- cu_instruction_o  out  instr_pkg::instruction_t  FIFO head.
- cu_instr_ready_i  in  1  control unit takes the head.
- cu_resp_valid_i  in  1  control unit response offered.
- cu_response_i  in  instr_pkg::nmcu_cpu_resp_t  response payload.
- cu_resp_ready_o  out  1  response buffer empty.
- cpu_resp_valid_o  out  1  buffered response to the CPU.
- cpu_response_o  out  instr_pkg::nmcu_cpu_resp_t  buffered response.
- cpu_resp_ready_i  in  1  CPU accepts the response.
- occupancy_o  out  CNT_WIDTH  entries currently queued.
- halted_o  out  1  HALT enqueued, response not yet delivered.
- instr_count_o  out  16  instructions accepted (stats).
- resp_count_o  out  16  responses delivered (stats).

## Operation
- Push: occurs when cpu_instr_valid_i && cpu_instr_ready_o.
  - cpu_instr_ready_o = !full && !halted_o. Purely registered terms; no dependence on the cu_* inputs.
- Pop: occurs when cu_instr_valid_o && cu_instr_ready_i.
  - cu_instr_valid_o = !empty.
  - cu_instruction_o = storage[rd_ptr].
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. The occupancy counter is the full/empty reference: full = (occupancy == DEPTH), empty = (occupancy == 0).
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - When full, push is blocked even if a pop occurs in the same cycle. There is no full-bypass.
- There is no empty-bypass. A pushed instruction is never visible downstream in the cycle it is written.
- HALT handling:
  - Pushing an instruction with opcode == INSTR_HALT sets halted_o on the next edge.
  - Instructions queued before the HALT drain normally.
  - halted_o clears on the edge where a CPU response with status == RESP_STATUS_HALT completes its cpu_resp handshake.
- Response buffer: one entry.
  - cu_resp_ready_o = !resp_buf_valid.
  - A cu_resp handshake loads the buffer and sets resp_buf_valid.
  - A cpu_resp handshake clears resp_buf_valid.
  - cpu_resp_valid_o = resp_buf_valid; cpu_response_o is the buffered payload.
  - Load and clear never occur in the same cycle, because load requires the buffer to be empty.
- Illegal conditions (assertion only, no recovery logic):
  - pop while empty;
  - cu_resp_valid_i dropped before the handshake.

## Timing
- Push-to-cu_instr_valid_o latency: 1 cycle (push at edge N, valid after edge N).
- cpu_instr_ready_o deasserts in the cycle after the push that fills the queue or that enqueues a HALT.
- Response latency: 1 cycle from cu_resp handshake to cpu_resp_valid_o.
  - Maximum response throughput is 1 per 2 cycles.
- Reset values: cpu_instr_ready_o=1, cu_instr_valid_o=0, cpu_resp_valid_o=0, cu_resp_ready_o=1, occupancy_o=0, halted_o=0, counts=0.
  - cu_instruction_o and cpu_response_o are don't-care while their valid is low.
- Reset mid-operation: pointers, occupancy, resp_buf_valid, halted_o and counters clear asynchronously. In-flight entries are discarded. FIFO storage is not reset.

## Configuration
- NMCU_IQ_STATS_EN defined:
  - instr_count_o increments on each push.
  - resp_count_o increments on each cpu_resp handshake.
  - Both are 16-bit, wrap from 16'hFFFF to 0, and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are generated. Ports are present in both builds.

## Structure
- nmcu_pkg: IQ_DEPTH default (4).
- instr_pkg: RESP_STATUS_OK = 2'b00 and RESP_STATUS_HALT = 2'b01, shared with the control unit.
- Sub-module nmcu_sync_fifo: generic type-parameterised FIFO with DEPTH, push/pop, full/empty and occupancy.
  - nmcu_instr_queue instantiates it for instruction_t.
  - HALT tracking, the response buffer and the stats counters stay in the top module.

## Test plan
- Reset, then push LOAD (addr_a=0x10) at edge 1 with cu_instr_ready_i=0 -> cu_instr_valid_o=1 after edge 1, occupancy_o=1, head addr_a=0x10.
- Push 4 NOPs with cu_instr_ready_i=0 (DEPTH=4) -> cpu_instr_ready_o=0 after the 4th push. A 5th valid is not accepted even while a pop occurs in that cycle. Order preserved on drain.
- Continuous push and pop at full rate across 9 instructions -> FIFO order preserved through pointer wrap; occupancy_o holds steady.
- Push MAC then HALT -> halted_o=1 and cpu_instr_ready_o=0. MAC still dispatches. After the HALT response (status 2'b01) is accepted, halted_o=0 and ready=1.
- Response with cpu_resp_ready_i=0 for 3 cycles -> cpu_resp_valid_o stays 1 with a stable payload (data=42), cu_resp_ready_o=0; released on the first ready cycle.
- Assert rst_n=0 with 3 entries queued and a response buffered -> all outputs return to reset values immediately. With NMCU_IQ_STATS_EN, counts read 0.
